// File: rtl/alu_nibble_seq.sv
// Wide-word ALU sequencer: drives a 4-bit ALU one nibble per cycle, LSB first, chaining carry.
// Define ALU_SEQ_BACK2BACK_EN to accept a new request in the same cycle as the response handshake.
module alu_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [2:0]             i_req_op,
  input  logic [4*NIBBLES-1:0]   i_req_a,
  input  logic [4*NIBBLES-1:0]   i_req_b,
  output logic                   o_resp_valid,
  input  logic                   i_resp_ready,
  output logic [4*NIBBLES-1:0]   o_resp_result,
  output logic                   o_resp_zero,
  output logic                   o_resp_carry,
  output logic                   o_resp_overflow,
  output logic                   o_resp_size,
  output logic [3:0]             o_alu_a,
  output logic [3:0]             o_alu_b,
  output logic [2:0]             o_alu_c,
  output logic                   o_alu_cin,
  input  logic [3:0]             i_alu_result,
  input  logic                   i_alu_carry,
  input  logic                   i_alu_overflow
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam logic [2:0] KMax = 3'(NIBBLES - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpNot = 3'b010;
  localparam logic [2:0] OpSlt = 3'b110;
  localparam logic [2:0] OpEq  = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state, w_state_next;
  logic [2:0]     r_op;
  logic [W-1:0]   r_a, r_b, r_result;
  logic [2:0]     r_k;
  logic           r_carry, r_zero, r_ovf;

  logic w_accept, w_last, w_done, w_arith, w_inv, w_inv_req;

  assign w_accept  = i_req_valid && o_req_ready;
  assign w_last    = (r_k == KMax);
  assign w_done    = (r_state == StDone);
  assign w_arith   = (r_op == OpAdd) || (r_op == OpSub) || (r_op == OpSlt) || (r_op == OpEq);
  assign w_inv     = (r_op == OpSub) || (r_op == OpSlt) || (r_op == OpEq);
  assign w_inv_req = (i_req_op == OpSub) || (i_req_op == OpSlt) || (i_req_op == OpEq);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_next = StRun;
      StRun:  if (w_last) w_state_next = StDone;
      StDone: begin
        if (i_resp_ready) begin
`ifdef ALU_SEQ_BACK2BACK_EN
          w_state_next = w_accept ? StRun : StIdle;
`else
          w_state_next = StIdle;
`endif
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_alu_a      = 4'h0;
    o_alu_b      = 4'h0;
    o_alu_c      = 3'b000;
    o_alu_cin    = 1'b0;
    unique case (r_state)
      StIdle: o_req_ready = 1'b1;
      StRun: begin
        // Arith ops always use ALU add with inverted b; ALU sub cannot chain carry.
        o_alu_a = r_a[3:0];
        if (w_arith) begin
          o_alu_b   = w_inv ? ~r_b[3:0] : r_b[3:0];
          o_alu_cin = r_carry;
        end else begin
          o_alu_c = r_op;
          o_alu_b = (r_op == OpNot) ? 4'h0 : r_b[3:0];
        end
      end
      StDone: begin
        o_resp_valid = 1'b1;
`ifdef ALU_SEQ_BACK2BACK_EN
        o_req_ready  = i_resp_ready;
`endif
      end
      default: ;
    endcase
  end

  // Operands shift right one nibble per cycle; result nibbles enter from the top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op     <= 3'b000;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_k      <= 3'd0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_op    <= i_req_op;
      r_a     <= i_req_a;
      r_b     <= i_req_b;
      r_k     <= 3'd0;
      r_carry <= w_inv_req;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
    end else if (r_state == StRun) begin
      r_a      <= r_a >> 4;
      r_b      <= r_b >> 4;
      r_result <= {i_alu_result, r_result[W-1:4]};
      r_carry  <= w_arith & i_alu_carry;
      r_zero   <= r_zero & ~|i_alu_result;
      r_k      <= r_k + 3'd1;
      if (w_last) r_ovf <= w_arith & i_alu_overflow;
    end
  end

  assign o_resp_result   = w_done ? r_result : '0;
  assign o_resp_zero     = w_done & r_zero;
  assign o_resp_carry    = w_done & w_arith & r_carry;
  assign o_resp_overflow = w_done & r_ovf;
  assign o_resp_size     = w_done & (((r_op == OpSlt) & (r_result[W-1] ^ r_ovf)) |
                                     ((r_op == OpEq) & r_zero));

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed self-checking bench for alu_nibble_seq with a behavioural 4-bit ALU attached.
module tb_alu_nibble_seq;

  localparam int unsigned NIBBLES = 4;
`ifdef ALU_SEQ_BACK2BACK_EN
  localparam int GAP = NIBBLES + 1;
`else
  localparam int GAP = NIBBLES + 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [15:0] req_a = 16'h0, req_b = 16'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_result;
  logic        resp_zero, resp_carry, resp_overflow, resp_size;
  logic [3:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_c;
  logic        alu_cin, alu_carry, alu_overflow;
  logic [4:0]  alu_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_op       (req_op),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .o_resp_valid   (resp_valid),
    .i_resp_ready   (resp_ready),
    .o_resp_result  (resp_result),
    .o_resp_zero    (resp_zero),
    .o_resp_carry   (resp_carry),
    .o_resp_overflow(resp_overflow),
    .o_resp_size    (resp_size),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_c        (alu_c),
    .o_alu_cin      (alu_cin),
    .i_alu_result   (alu_result),
    .i_alu_carry    (alu_carry),
    .i_alu_overflow (alu_overflow)
  );

  // 4-bit ALU: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor.
  always_comb begin
    alu_sum      = 5'd0;
    alu_result   = 4'h0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_c)
      3'b000: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_result   = alu_sum[3:0];
        alu_carry    = alu_sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      3'b001: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_result   = alu_sum[3:0];
        alu_carry    = alu_sum[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      3'b010:  alu_result = ~alu_a;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      default: alu_result = 4'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ez,
                        input logic ec, input logic ev, input logic es, input int stall);
    int  lat;
    logic arith;
    arith = (op == 3'b000) || (op == 3'b001) || (op == 3'b110) || (op == 3'b111);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      if (lat == 0) check({tag, ".alu_a0"}, 32'(alu_a), 32'(a[3:0]));
      if (arith) begin
        check({tag, ".alu_c"}, 32'(alu_c), 32'd0);
        if (lat == 0) check({tag, ".alu_cin0"}, 32'(alu_cin), 32'(op != 3'b000));
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(NIBBLES));
    check({tag, ".result"}, 32'(resp_result), 32'(er));
    check({tag, ".zero"}, 32'(resp_zero), 32'(ez));
    check({tag, ".carry"}, 32'(resp_carry), 32'(ec));
    check({tag, ".ovf"}, 32'(resp_overflow), 32'(ev));
    check({tag, ".size"}, 32'(resp_size), 32'(es));
    check({tag, ".done_ready"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".stall_result"}, 32'(resp_result), 32'(er));
      check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".handshake"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int first, second;
    bit saw;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.result", 32'(resp_result), 32'd0);
    check("rst.flags", 32'({resp_zero, resp_carry, resp_overflow, resp_size}), 32'd0);
    check("rst.alu", 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);

    run_op("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    run_op("add_zero", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    run_op("sub", 3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op("slt", 3'b110, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    run_op("eq", 3'b111, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    run_op("xor", 3'b101, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    run_op("not", 3'b010, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op("and", 3'b011, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_op("or", 3'b100, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Abort a transaction while nibble 2 is on the ALU.
    req_op = 3'b000;
    req_a = 16'h1111;
    req_b = 16'h2222;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.alu", 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);
    saw = 1'b0;
    resp_ready = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) saw = 1'b1;
    end
    resp_ready = 1'b0;
    check("abort.no_resp", 32'(saw), 32'd0);

    // Back-to-back requests with the consumer always ready.
    first = -1;
    second = -1;
    req_op = 3'b000;
    req_a = 16'h0001;
    req_b = 16'h0002;
    req_valid = 1'b1;
    resp_ready = 1'b1;
    for (int e = 0; e < 40 && second < 0; e++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        if (first < 0) begin
          first = e;
          check("b2b.result", 32'(resp_result), 32'h0003);
        end else begin
          second = e;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b.gap", 32'(second - first), 32'(GAP));
    repeat (12) @(posedge clk);
    resp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
